// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one ALU among NUM_REQ requesters and
// registers each result into a single-entry response buffer tagged with the requester id.
module alu #(
    parameter int unsigned WORD_LEN = 8
) (
    input  logic [3:0]          op_select,
    input  logic [WORD_LEN-1:0] a,
    input  logic [WORD_LEN-1:0] b,
    output logic [WORD_LEN-1:0] result,
    output logic                zero,
    output logic                carry
);
    logic [WORD_LEN:0] wide;

    // 0x0 add (carry out), 0x1 sub (carry = borrow), 0x2 and, 0x8 or, 0x9 xor
    always_comb begin
        wide = '0;
        case (op_select)
            4'h0:    wide = {1'b0, a} + {1'b0, b};
            4'h1:    wide = {1'b0, a} - {1'b0, b};
            4'h2:    wide = {1'b0, a & b};
            4'h8:    wide = {1'b0, a | b};
            4'h9:    wide = {1'b0, a ^ b};
            default: wide = '0;
        endcase
        result = wide[WORD_LEN-1:0];
        carry  = wide[WORD_LEN];
        zero   = (wide[WORD_LEN-1:0] == '0);
    end
endmodule

module alu_arbiter #(
    parameter int unsigned WORD_LEN = 8,
    parameter int unsigned NUM_REQ  = 4,
    localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [4*NUM_REQ-1:0]        req_op,
    input  logic [WORD_LEN*NUM_REQ-1:0] req_a,
    input  logic [WORD_LEN*NUM_REQ-1:0] req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [ID_W-1:0]             rsp_id,
    output logic [WORD_LEN-1:0]         rsp_result,
    output logic                        rsp_zero,
    output logic                        rsp_carry,
    output logic                        rsp_err
);
    logic [ID_W-1:0]     ptr_q, ptr_d, gnt;
    logic                found, accept, xfer, legal;
    int unsigned         idx;
    logic [3:0]          sel_op;
    logic [WORD_LEN-1:0] sel_a, sel_b, alu_result;
    logic                alu_zero, alu_carry;

    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [WORD_LEN-1:0] rsp_result_q, rsp_result_d;
    logic                rsp_zero_q, rsp_zero_d;
    logic                rsp_carry_q, rsp_carry_d;
    logic                rsp_err_q, rsp_err_d;

    // First valid requester at or after ptr, wrapping modulo NUM_REQ
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(ptr_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gnt   = ID_W'(idx);
            end
        end
    end

    assign accept    = !rsp_valid_q || rsp_ready;
    assign xfer      = accept && found && !rst;
    assign req_ready = xfer ? (NUM_REQ'(1) << gnt) : '0;

    assign sel_op = req_op[32'(gnt)*4 +: 4];
    assign sel_a  = req_a[32'(gnt)*WORD_LEN +: WORD_LEN];
    assign sel_b  = req_b[32'(gnt)*WORD_LEN +: WORD_LEN];
    assign legal  = (sel_op == 4'h0) || (sel_op == 4'h1) || (sel_op == 4'h2) ||
                    (sel_op == 4'h8) || (sel_op == 4'h9);

    alu #(.WORD_LEN(WORD_LEN)) u_alu (
        .op_select (sel_op),
        .a         (sel_a),
        .b         (sel_b),
        .result    (alu_result),
        .zero      (alu_zero),
        .carry     (alu_carry)
    );

    always_comb begin
        ptr_d        = ptr_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_err_d    = rsp_err_q;
        if (xfer) begin
            ptr_d        = (32'(gnt) == NUM_REQ - 1) ? '0 : gnt + 1'b1;
            rsp_valid_d  = 1'b1;
            rsp_id_d     = gnt;
            rsp_result_d = legal ? alu_result : '0;
            rsp_zero_d   = legal && alu_zero;
            rsp_carry_d  = legal && alu_carry;
            rsp_err_d    = !legal;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_carry_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_carry  = rsp_carry_q;
    assign rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, round-robin order, sparse requests,
// backpressure, illegal ops and a randomised traffic sweep against a local model.
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [15:0] req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_result;
    logic        rsp_zero, rsp_carry, rsp_err;

    int checks = 0;
    int errors = 0;
    logic [13:0] obs, exp;
    logic [3:0]  legal_ops [5] = '{4'h0, 4'h1, 4'h2, 4'h8, 4'h9};

    alu_arbiter #(.WORD_LEN(8), .NUM_REQ(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
        .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    assign obs = {rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_carry, rsp_err};

    // Expected response vector {valid,id,result,zero,carry,err}
    function automatic logic [13:0] exp_rsp(input logic v, input logic [1:0] id,
                                            input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
        logic [8:0] t;
        logic       e;
        t = '0;
        e = 1'b0;
        case (op)
            4'h0: t = {1'b0, a} + {1'b0, b};
            4'h1: t = {1'b0, a} - {1'b0, b};
            4'h2: t = {1'b0, a & b};
            4'h8: t = {1'b0, a | b};
            4'h9: t = {1'b0, a ^ b};
            default: e = 1'b1;
        endcase
        return {v, id, t[7:0], (!e && t[7:0] == 8'h00), t[8], e};
    endfunction

    function automatic logic [13:0] exp_of(input int i);
        return exp_rsp(1'b1, 2'(i), req_op[i*4 +: 4], req_a[i*8 +: 8], req_b[i*8 +: 8]);
    endfunction

    task automatic set_req(input int i, input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] b);
        req_op[i*4 +: 4] = op;
        req_a[i*8 +: 8]  = a;
        req_b[i*8 +: 8]  = b;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        for (int i = 0; i < 4; i++) set_req(i, 4'h0, 8'(i + 1), 8'h10);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 14'h0) begin
            errors++; $display("FAIL reset_async_outputs: got %h want %h", obs, 14'h0);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_ready_low: got %b want 0000", req_ready);
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_hold: ready %b valid %b want 0000 0", req_ready, rsp_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL reset_first_grant: got %b want 0001", req_ready);
        end
        @(posedge clk); @(negedge clk);
        exp = exp_of(0);
        checks++;
        if (obs !== exp) begin
            errors++; $display("FAIL reset_first_rsp: got %h want %h", obs, exp);
        end
    endtask

    task automatic test_round_robin;
        do_reset;
        set_req(0, 4'h1, 8'hF0, 8'h0F);
        set_req(1, 4'h0, 8'hFF, 8'h01);
        set_req(2, 4'h2, 8'hF0, 8'h0F);
        set_req(3, 4'h9, 8'hAA, 8'h55);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (req_ready !== (4'b0001 << (k % 4))) begin
                errors++; $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, 4'b0001 << (k % 4));
            end
            @(posedge clk); @(negedge clk);
            exp = exp_of(k % 4);
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL rr_rsp[%0d]: got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_sparse;
        int seq [4] = '{1, 3, 0, 1};
        do_reset;
        for (int i = 0; i < 4; i++) set_req(i, 4'h8, 8'(i * 16), 8'h01);
        req_valid = 4'b1010;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) req_valid = 4'b1011;
            #1;
            checks++;
            if (req_ready !== (4'b0001 << seq[k])) begin
                errors++; $display("FAIL sparse_ready[%0d]: got %b want %b", k, req_ready, 4'b0001 << seq[k]);
            end
            @(posedge clk); @(negedge clk);
            exp = exp_of(seq[k]);
            checks++;
            if (obs !== exp) begin
                errors++; $display("FAIL sparse_rsp[%0d]: got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_backpressure;
        do_reset;
        set_req(0, 4'h0, 8'h12, 8'h34);
        req_valid = 4'b0001;
        @(posedge clk); @(negedge clk);
        set_req(0, 4'h1, 8'h05, 8'h07);
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000 || obs !== {1'b1, 2'd0, 8'h46, 1'b0, 1'b0, 1'b0}) begin
                errors++; $display("FAIL bp_frozen[%0d]: ready %b rsp %h want 0000 %h", k, req_ready, obs,
                                   {1'b1, 2'd0, 8'h46, 1'b0, 1'b0, 1'b0});
            end
            @(posedge clk); @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL bp_same_cycle_accept: got %b want 0001", req_ready);
        end
        @(posedge clk); @(negedge clk);
        checks++;
        if (obs !== {1'b1, 2'd0, 8'hFE, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL bp_refill: got %h want %h", obs, {1'b1, 2'd0, 8'hFE, 1'b0, 1'b1, 1'b0});
        end
        req_valid = 4'b0000;
        @(posedge clk); @(negedge clk);
        checks++;
        if (obs !== {1'b0, 2'd0, 8'hFE, 1'b0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL bp_drain_hold: got %h want %h", obs, {1'b0, 2'd0, 8'hFE, 1'b0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_illegal;
        logic [3:0]  ops  [3] = '{4'h3, 4'hA, 4'h9};
        logic [13:0] want [3] = '{{1'b1, 2'd2, 8'h00, 1'b0, 1'b0, 1'b1},
                                  {1'b1, 2'd2, 8'h00, 1'b0, 1'b0, 1'b1},
                                  {1'b1, 2'd2, 8'hFE, 1'b0, 1'b0, 1'b0}};
        do_reset;
        rsp_ready = 1'b1;
        req_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            set_req(2, ops[k], 8'hFF, 8'h01);
            @(posedge clk); @(negedge clk);
            checks++;
            if (obs !== want[k]) begin
                errors++; $display("FAIL illegal_op[%h]: got %h want %h", ops[k], obs, want[k]);
            end
        end
    endtask

    task automatic test_sweep;
        logic [13:0] m_rsp;
        logic [1:0]  m_ptr;
        logic [3:0]  exp_ready;
        int          g, j, acc_g;
        int          in_cnt [4];
        int          out_cnt [4];
        int          total;
        do_reset;
        m_rsp = '0;
        m_ptr = '0;
        acc_g = -1;
        total = 0;
        for (int i = 0; i < 4; i++) begin in_cnt[i] = 0; out_cnt[i] = 0; end
        for (int c = 0; c < 3000; c++) begin
            checks++;
            if (obs !== m_rsp) begin
                errors++; $display("FAIL sweep_rsp[%0d]: got %h want %h", c, obs, m_rsp);
            end
            if (acc_g >= 0) req_valid[acc_g] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (c < 2980 && !req_valid[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, legal_ops[$urandom_range(0, 4)], 8'($urandom), 8'($urandom));
                    req_valid[i] = 1'b1;
                    in_cnt[i]++;
                end
            end
            rsp_ready = (c >= 2980) ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            if (rsp_valid && rsp_ready) out_cnt[rsp_id]++;
            g = -1;
            if (!m_rsp[13] || rsp_ready) begin
                for (int k = 0; k < 4; k++) begin
                    j = (int'(m_ptr) + k) % 4;
                    if (g < 0 && req_valid[j]) g = j;
                end
            end
            exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            checks++;
            if (req_ready !== exp_ready) begin
                errors++; $display("FAIL sweep_ready[%0d]: got %b want %b", c, req_ready, exp_ready);
            end
            if (g >= 0) begin
                m_rsp = exp_of(g);
                m_ptr = 2'((g + 1) % 4);
            end else if (rsp_ready) begin
                m_rsp[13] = 1'b0;
            end
            acc_g = g;
            @(posedge clk); @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            total += in_cnt[i];
            checks++;
            if (out_cnt[i] !== in_cnt[i]) begin
                errors++; $display("FAIL sweep_count[%0d]: got %0d responses want %0d", i, out_cnt[i], in_cnt[i]);
            end
        end
        checks++;
        if (total < 500) begin
            errors++; $display("FAIL sweep_traffic: got %0d requests want at least 500", total);
        end
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_sparse;
        test_backpressure;
        test_illegal;
        test_sweep;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
